// File: rtl/id_hazard_fwd.sv
// id_hazard_fwd: ID/EX operand bypass, latency scoreboard stall, and ID/EX pipeline register
module id_hazard_fwd #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int MAX_LAT = 4,
  parameter int AOP_W   = 8,
  parameter int ASEL_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid_i,
  input  logic                       flush_i,
  input  logic [NUM_RD-1:0]          rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  input  logic [NUM_RD*DATA_W-1:0]   rf_data_i,
  input  logic [DATA_W-1:0]          imm_i,
  input  logic                       wreg_i,
  input  logic [ADDR_W-1:0]          wd_i,
  input  logic [$clog2(MAX_LAT):0]   lat_i,
  input  logic [AOP_W-1:0]           aluop_i,
  input  logic [ASEL_W-1:0]          alusel_i,
  input  logic                       ex_wreg_i,
  input  logic [ADDR_W-1:0]          ex_wd_i,
  input  logic [DATA_W-1:0]          ex_wdata_i,
  input  logic                       mem_wreg_i,
  input  logic [ADDR_W-1:0]          mem_wd_i,
  input  logic [DATA_W-1:0]          mem_wdata_i,
  output logic                       stall_o,
  output logic                       ex_valid_o,
  output logic [NUM_RD*DATA_W-1:0]   ex_op_o,
  output logic                       ex_wreg_o,
  output logic [ADDR_W-1:0]          ex_wd_o,
  output logic [AOP_W-1:0]           ex_aluop_o,
  output logic [ASEL_W-1:0]          ex_alusel_o
);
  localparam int CNT_W = $clog2(MAX_LAT);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W:0] LMAX = (CNT_W+1)'(MAX_LAT);
  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W:0] lat_sat;
  logic [CNT_W-1:0] lat_m1;
  logic [NUM_RD-1:0] raw;
  logic [NUM_RD*DATA_W-1:0] op;
  logic wd_nz, waw, issue, bubble;
  assign lat_sat = (lat_i == '0) ? (CNT_W+1)'(1) : (lat_i > LMAX) ? LMAX : lat_i;
  assign lat_m1 = CNT_W'(lat_sat - 1'b1);
  assign wd_nz = wd_i != '0;
  assign waw = id_valid_i & wreg_i & wd_nz & (cnt[wd_i] > lat_m1);
  assign stall_o = ~rst & id_valid_i & ~flush_i & (|raw | waw);
  assign issue = id_valid_i & ~stall_o & ~flush_i & wreg_i & wd_nz;
  assign bubble = rst | flush_i | stall_o | ~id_valid_i;
  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_W-1:0] a;
    logic en;
    assign a = rd_addr_i[p*ADDR_W +: ADDR_W];
    assign en = rd_en_i[p];
    assign raw[p] = en & (a != '0) & (cnt[a] != '0);
    assign op[p*DATA_W +: DATA_W] = !en ? imm_i :
                                    (a == '0) ? '0 :
                                    (ex_wreg_i && ex_wd_i == a) ? ex_wdata_i :
                                    (mem_wreg_i && mem_wd_i == a) ? mem_wdata_i :
                                    rf_data_i[p*DATA_W +: DATA_W];
  end
  // issue reloads an entry in the same cycle every other live entry counts down
  always_ff @(posedge clk)
    for (int r = 0; r < NREG; r++)
      cnt[r] <= (rst || r == 0) ? '0 :
                (issue && wd_i == ADDR_W'(r)) ? lat_m1 :
                (cnt[r] != '0) ? cnt[r] - 1'b1 : '0;
  always_ff @(posedge clk) begin
    ex_valid_o  <= ~bubble;
    ex_wreg_o   <= bubble ? 1'b0 : wreg_i;
    ex_wd_o     <= bubble ? '0 : wd_i;
    ex_op_o     <= bubble ? '0 : op;
    ex_aluop_o  <= bubble ? '0 : aluop_i;
    ex_alusel_o <= bubble ? '0 : alusel_i;
  end
endmodule

// File: tb/tb_id_hazard_fwd.sv
// tb_id_hazard_fwd: directed vectors with hand-computed expectations for id_hazard_fwd
module tb_id_hazard_fwd;
  logic clk = 0, rst = 1;
  logic id_valid = 0, flush = 0, wreg = 0;
  logic [1:0] rd_en = 0;
  logic [9:0] rd_addr = 0;
  logic [63:0] rf_data = 0;
  logic [31:0] imm = 0;
  logic [4:0] wd = 0;
  logic [2:0] lat = 0;
  logic [7:0] aluop = 0;
  logic [2:0] alusel = 0;
  logic ex_wreg = 0, mem_wreg = 0;
  logic [4:0] ex_wd = 0, mem_wd = 0;
  logic [31:0] ex_wdata = 0, mem_wdata = 0;
  logic stall, ex_valid, ex_wreg_q;
  logic [63:0] ex_op;
  logic [4:0] ex_wd_q;
  logic [7:0] ex_aluop;
  logic [2:0] ex_alusel;
  int total = 0, bad = 0;

  id_hazard_fwd dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .flush_i(flush),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rf_data_i(rf_data), .imm_i(imm),
    .wreg_i(wreg), .wd_i(wd), .lat_i(lat), .aluop_i(aluop), .alusel_i(alusel),
    .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
    .stall_o(stall), .ex_valid_o(ex_valid), .ex_op_o(ex_op),
    .ex_wreg_o(ex_wreg_q), .ex_wd_o(ex_wd_q), .ex_aluop_o(ex_aluop), .ex_alusel_o(ex_alusel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                       input logic w, input logic [4:0] d, input logic [2:0] l);
    id_valid = 1; flush = 0; rd_en = en; rd_addr = {a1, a0};
    rf_data = {32'h2000_0000 + {27'd0, a1}, 32'h1000_0000 + {27'd0, a0}};
    imm = 32'hCAFE_0001; wreg = w; wd = d; lat = l; aluop = 8'h5A; alusel = 3'd2;
  endtask

  task automatic no_byp;
    ex_wreg = 0; ex_wd = 0; ex_wdata = 0; mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
  endtask

  initial begin
    tick; tick;
    rst = 0;
    // reset mid-traffic: mul r9 in flight, then reset drops it
    instr(2'b11, 5'd1, 5'd2, 1, 5'd9, 3'd4);
    tick;
    chk("mul_valid", ex_valid, 1);
    chk("mul_wd", ex_wd_q, 9);
    chk("mul_ops", ex_op, 64'h2000_0002_1000_0001);
    chk("mul_aluop", ex_aluop, 8'h5A);
    rst = 1;
    instr(2'b01, 5'd9, 5'd0, 1, 5'd10, 3'd1);
    #1 chk("rst_stall", stall, 0);
    tick;
    chk("rst_valid", ex_valid, 0);
    chk("rst_op", ex_op, 0);
    chk("rst_wd", ex_wd_q, 0);
    chk("rst_aluop", {ex_aluop, ex_alusel, ex_wreg_q}, 0);
    tick;
    chk("rst2_valid", ex_valid, 0);
    rst = 0;
    #1 chk("post_rst_stall", stall, 0);
    tick;
    chk("post_rst_op", ex_op, 64'hCAFE_0001_1000_0009);
    // ALU chain via EX bypass
    instr(2'b11, 5'd1, 5'd2, 1, 5'd3, 3'd1);
    #1 chk("or_stall", stall, 0);
    tick;
    instr(2'b11, 5'd3, 5'd3, 1, 5'd4, 3'd1);
    ex_wreg = 1; ex_wd = 3; ex_wdata = 32'h00FF;
    #1 chk("and_stall", stall, 0);
    tick;
    chk("and_ops", ex_op, 64'h0000_00FF_0000_00FF);
    chk("and_wd", ex_wd_q, 4);
    no_byp;
    // load-use: one stall cycle then MEM bypass
    instr(2'b01, 5'd1, 5'd0, 1, 5'd5, 3'd2);
    tick;
    instr(2'b11, 5'd5, 5'd1, 1, 5'd6, 3'd1);
    #1 chk("lu_stall1", stall, 1);
    tick;
    chk("lu_bubble", ex_valid, 0);
    mem_wreg = 1; mem_wd = 5; mem_wdata = 32'h1234;
    #1 chk("lu_stall2", stall, 0);
    tick;
    chk("lu_valid", ex_valid, 1);
    chk("lu_ops", ex_op, 64'h2000_0001_0000_1234);
    no_byp;
    // r0 guard and unread port takes immediate
    instr(2'b01, 5'd0, 5'd7, 1, 5'd10, 3'd1);
    ex_wreg = 1; ex_wd = 0; ex_wdata = 32'hDEAD;
    #1 chk("r0_stall", stall, 0);
    tick;
    chk("r0_ops", ex_op, 64'hCAFE_0001_0000_0000);
    no_byp;
    // mul latency 4 -> three stall cycles
    instr(2'b11, 5'd1, 5'd2, 1, 5'd7, 3'd4);
    tick;
    instr(2'b01, 5'd7, 5'd0, 1, 5'd11, 3'd1);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mul_stall%0d", i), stall, 1);
      tick;
    end
    chk("mul_bubble", ex_valid, 0);
    chk("mul_go", stall, 0);
    tick;
    chk("mul_dep_op", ex_op, 64'hCAFE_0001_1000_0007);
    // same with flush in stall cycle 2; scoreboard keeps counting
    instr(2'b11, 5'd1, 5'd2, 1, 5'd7, 3'd4);
    tick;
    instr(2'b01, 5'd7, 5'd0, 1, 5'd11, 3'd1);
    #1 chk("fl_stall1", stall, 1);
    tick;
    flush = 1;
    #1 chk("fl_stall_flush", stall, 0);
    tick;
    chk("fl_bubble", ex_valid, 0);
    flush = 0;
    #1 chk("fl_stall3", stall, 1);
    tick;
    chk("fl_go", stall, 0);
    tick;
    chk("fl_valid", ex_valid, 1);
    // lat 0 acts as 1, lat 7 saturates to 4
    instr(2'b11, 5'd1, 5'd2, 1, 5'd13, 3'd0);
    tick;
    instr(2'b01, 5'd13, 5'd0, 1, 5'd14, 3'd1);
    #1 chk("lat0_stall", stall, 0);
    tick;
    instr(2'b11, 5'd1, 5'd2, 1, 5'd12, 3'd7);
    tick;
    instr(2'b01, 5'd12, 5'd0, 1, 5'd14, 3'd1);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("lat7_stall%0d", i), stall, 1);
      tick;
    end
    chk("lat7_go", stall, 0);
    tick;
    // WAW: addi r8 waits for mul r8
    instr(2'b11, 5'd1, 5'd2, 1, 5'd8, 3'd4);
    tick;
    instr(2'b01, 5'd1, 5'd0, 1, 5'd8, 3'd1);
    alusel = 3'd5;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("waw_stall%0d", i), stall, 1);
      tick;
    end
    chk("waw_go", stall, 0);
    tick;
    chk("waw_wd", {ex_valid, ex_wreg_q, ex_wd_q}, {2'b11, 5'd8});
    chk("waw_alusel", ex_alusel, 5);
    // EX beats MEM on the same address
    instr(2'b01, 5'd2, 5'd0, 0, 5'd0, 3'd1);
    ex_wreg = 1; ex_wd = 2; ex_wdata = 32'hEEEE;
    mem_wreg = 1; mem_wd = 2; mem_wdata = 32'h3333;
    tick;
    chk("pri_ops", ex_op, 64'hCAFE_0001_0000_EEEE);
    chk("pri_wreg", ex_wreg_q, 0);
    no_byp;
    id_valid = 0;
    tick;
    chk("idle_valid", ex_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
